// File: rtl/cla_seq_addsub.sv
// Multi-cycle carry-lookahead adder/subtractor: an N-bit operand pair is
// pushed through one G-bit lookahead slice per clock with a registered carry.

module cla_seq_addsub_slice #(
  parameter int G = 4
) (
  input  logic [G-1:0] a,
  input  logic [G-1:0] b,
  input  logic         ci,
  output logic [G-1:0] s,
  output logic         co,
  output logic         c_msb
);
  logic [G-1:0] g, p;
  logic [G:0]   c;

  // Every carry is expanded into its full generate/propagate sum-of-products
  // so no carry depends on a rippled neighbour.
  always_comb begin
    logic t, pr;
    t    = 1'b0;
    pr   = 1'b0;
    g    = a & b;
    p    = a | b;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < G; i++) begin
      t  = g[i];
      pr = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        t  = t | (pr & g[j]);
        pr = pr & p[j];
      end
      c[i+1] = t | (pr & ci);
    end
  end

  assign s     = a ^ b ^ c[G-1:0];
  assign co    = c[G];
  assign c_msb = c[G-1];
endmodule

module cla_seq_addsub #(
  parameter int N = 16,
  parameter int G = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf,
  output logic         zero
);
  localparam int SLICES = N / G;
  localparam int IDXW   = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(SLICES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            c_out_q, c_out_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;

  logic [G-1:0] sl_a, sl_b, sl_s;
  logic         sl_co, sl_cmsb;

  assign sl_a = a_q[idx_q*G +: G];
  assign sl_b = b_q[idx_q*G +: G];

  cla_seq_addsub_slice #(.G(G)) u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .ci    (carry_q),
    .s     (sl_s),
    .co    (sl_co),
    .c_msb (sl_cmsb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtract is a + ~b + 1, so the injected carry replaces c_in.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : c_in;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[idx_q*G +: G] = sl_s;
        carry_d             = sl_co;
        idx_d               = idx_q + IDXW'(1);
        if (idx_q == LAST) begin
          c_out_d = sl_co;
          ovf_d   = sl_cmsb ^ sl_co;
          zero_d  = (sum_d == '0);
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_cla_seq_addsub.sv
// Directed bench for cla_seq_addsub at N=16, G=4 with hand-computed results.

module tb_cla_seq_addsub;
  localparam int N = 16;
  localparam int G = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         zero;

  int checks = 0;
  int errors = 0;

  cla_seq_addsub #(.N(N), .G(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Issue one op and wait for out_valid; leaves the DUT sitting in DONE.
  task automatic issue(input logic [N-1:0] va, input logic [N-1:0] vb,
                       input logic vc, input logic vs, input string tag);
    int cyc;
    @(negedge clk);
    a = va; b = vb; c_in = vc; sub = vs; in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~va; b = ~vb; c_in = ~vc; sub = ~vs;
    chk({tag, ".busy"}, 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'd4);
  endtask

  task automatic expect_res(input string tag, input logic [N-1:0] es,
                            input logic ec, input logic eo, input logic ez);
    chk({tag, ".sum"},  32'(sum),   32'(es));
    chk({tag, ".cout"}, 32'(c_out), 32'(ec));
    chk({tag, ".ovf"},  32'(ovf),   32'(eo));
    chk({tag, ".zero"}, 32'(zero),  32'(ez));
    chk({tag, ".rdy"},  32'(in_ready), 32'd0);
  endtask

  task automatic release_res(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".idle_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, ".idle_ov"},  32'(out_valid), 32'd0);
  endtask

  task automatic op(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vc,
                    input logic vs, input logic [N-1:0] es, input logic ec,
                    input logic eo, input logic ez, input string tag);
    issue(va, vb, vc, vs, tag);
    expect_res(tag, es, ec, eo, ez);
    release_res(tag);
  endtask

  initial begin
    #12;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.sum", 32'(sum), 32'd0);
    chk("rst.flags", {29'd0, c_out, ovf, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, "add1");
    op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "wrap");
    op(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, "wrapc");
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "povf");
    op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, "sub1");
    op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, "novf");
    op(16'hA5A5, 16'hA5A5, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, "subz");

    // Backpressure: DONE held while inputs churn.
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, "bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      a = 16'(i * 16'h1111);
      b = 16'(16'hFFFF - i);
      @(posedge clk);
      #1;
      chk("bp.sum", 32'(sum), 32'h5555);
      chk("bp.ov", 32'(out_valid), 32'd1);
      chk("bp.rdy", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'h0F0F;
    b = 16'h0F0F;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("bp.nocap_rdy", 32'(in_ready), 32'd1);
    chk("bp.held_sum", 32'(sum), 32'h5555);

    // Async reset during the second RUN cycle, after flags were left set.
    op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, "pre");
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.sum", 32'(sum), 32'd0);
    chk("arst.flags", {29'd0, c_out, ovf, zero}, 32'd0);
    chk("arst.ov", 32'(out_valid), 32'd0);
    chk("arst.rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, "post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cla_seq_addsub.md
Name: cla_seq_addsub

Overview:
- Parametrised, multi-cycle carry-lookahead adder/subtractor.
- Processes an N-bit operand pair G bits per clock through a single G-bit lookahead slice and a registered inter-slice carry.
- Produces sum, carry-out, signed overflow and zero flags.
- Used by the execute stage where area matters more than latency; valid/ready handshakes on both sides.

Parameters:
- N, 16, operand/result width; must be a multiple of G.
- G, 4, slice width processed per cycle; N/G = number of compute cycles (G = N gives single-cycle compute).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  N  operand A.
- b  input  N  operand B.
- c_in  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  0: a+b+c_in; 1: a+~b+1 (a-b).
- out_valid  output  1  result valid (high only in DONE).
- out_ready  input  1  consumer accepts result.
- sum  output  N  registered result.
- c_out  output  1  carry out of bit N-1 (for sub: 1 = no borrow).
- ovf  output  1  signed overflow = carry into bit N-1 XOR carry out of bit N-1.
- zero  output  1  1 when sum == 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, slice index=0, carry reg=0; sum=0, c_out=0, ovf=0, zero=0, out_valid=0, in_ready=1. Takes effect immediately, including mid-RUN or in DONE; in-flight operation discarded, no partial result delivered.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE); out_valid = (state==DONE); both decoded from the state register, never from inputs.
- IDLE: on in_valid=1 at a rising edge:
  - capture a and b (b inverted when sub=1) into operand regs.
  - carry reg <= sub ? 1 : c_in.
  - index <= 0; go to RUN.
  - in_valid=0: stay in IDLE.
- RUN, each cycle:
  - slice bits [idx*G +: G] go through a G-bit lookahead: g_i=a_i&b_i, p_i=a_i|b_i, c_{i+1}=g_i|p_i&c_i; sum bits = a^b^c.
  - write those G sum bits into the sum reg; carry reg <= slice carry-out; idx++.
  - on the last slice (idx = N/G-1), additionally:
    - c_out <= slice carry-out.
    - ovf <= carry into MSB XOR slice carry-out.
    - zero <= (final full sum == 0), computed from the upper slice bits just written plus already-stored lower bits.
    - go to DONE.
- Latency: operands accepted at edge k; RUN spans edges k+1..k+N/G; out_valid high after edge k+N/G. Throughput: one op per N/G+2 cycles minimum.
- DONE: sum/c_out/ovf/zero held stable while out_valid=1.
  - out_ready=1 at an edge: go to IDLE.
  - out_ready=0: stay in DONE indefinitely.
  - in_valid is ignored (in_ready=0); no operand capture in DONE, even when out_ready=1 in the same cycle.
- Inputs a, b, c_in and sub are sampled only at the accepting edge; changes during RUN/DONE have no effect.
- sum reg is updated slice-by-slice during RUN; sum and flags are meaningful only while out_valid=1.
- Flags keep their last values in IDLE until the next DONE entry.
- Arithmetic is modulo 2^N; no saturation.

Test Plan (N=16, G=4):
- Add a=0x1234, b=0x4321, c_in=0, sub=0, accepted at edge k -> out_valid rises after edge k+4; sum=0x5555, c_out=0, ovf=0, zero=0; in_ready=0 until handshake completes.
- Add a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, ovf=0, zero=1. Same with c_in=1 -> sum=0x0001, zero=0.
- Add a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, ovf=1.
- Subtract with c_in=1 (c_in must be ignored):
  - a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_out=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, c_out=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after DONE while toggling in_valid and a/b -> outputs unchanged, in_ready=0, no new capture. Then out_ready=1 for one cycle -> IDLE next edge, in_ready=1.
- Reset mid-op: assert rst_n=0 asynchronously during the 2nd RUN cycle -> sum=0, flags=0, out_valid=0, in_ready=1 without waiting for a clock edge. After release, the next op (0x0001+0x0001) gives sum=0x0002 in 4 cycles.
